// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller for a dual-port RAM macro
// with a registered read port. It owns the pointers, the occupancy count
// and the status flags. RAM read data is passed straight through to the
// consumer, qualified by rvalid one cycle after an accepted pop.
module sync_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  output logic             almost_full,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             rempty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             wovf,
  output logic             rudf,
  output logic             ram_wenc,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_renc,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [CW-1:0] AF_LVL = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_LVL = CW'(AE_LEVEL);

  // Pointers carry one extra wrap bit above the RAM address.
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   wptr_next;
  logic [AW:0]   rptr_next;
  logic [CW-1:0] count_next;
  logic          push_ok;
  logic          pop_ok;

  // Accept decisions use last cycle's registered flags only.
  assign push_ok = winc & ~wfull;
  assign pop_ok  = rinc & ~rempty;

  assign ram_wenc  = push_ok;
  assign ram_waddr = wptr[AW-1:0];
  assign ram_wdata = wdata;
  assign ram_renc  = pop_ok;
  assign ram_raddr = rptr[AW-1:0];

  // The RAM read port is already registered, so data passes straight through.
  assign rdata = ram_rdata;

  // Next-state pointers and occupancy; flags are derived from these so they
  // are valid in the cycle right after the update.
  always_comb begin
    wptr_next  = wptr + (AW + 1)'(push_ok);
    rptr_next  = rptr + (AW + 1)'(pop_ok);
    count_next = count + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer, count, flag and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      almost_full  <= 1'b0;
      rempty       <= 1'b1;
      almost_empty <= 1'b1;
      rvalid       <= 1'b0;
      wovf         <= 1'b0;
      rudf         <= 1'b0;
    end else begin
      wptr         <= wptr_next;
      rptr         <= rptr_next;
      count        <= count_next;
      wfull        <= (wptr_next[AW-1:0] == rptr_next[AW-1:0]) &&
                      (wptr_next[AW] != rptr_next[AW]);
      rempty       <= (wptr_next == rptr_next);
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
      rvalid       <= pop_ok;
      wovf         <= winc & wfull;
      rudf         <= rinc & rempty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Testbench for sync_fifo_ctrl: a queue-based reference model plus a
// behavioural registered-read RAM attached to the controller's RAM ports.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             winc;
  logic [WIDTH-1:0] wdata;
  logic             wfull;
  logic             almost_full;
  logic             rinc;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rempty;
  logic             almost_empty;
  logic [4:0]       count;
  logic             wovf;
  logic             rudf;
  logic             ram_wenc;
  logic [3:0]       ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_renc;
  logic [3:0]       ram_raddr;
  logic [WIDTH-1:0] ram_rdata;

  sync_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull),
    .almost_full(almost_full), .rinc(rinc), .rdata(rdata), .rvalid(rvalid),
    .rempty(rempty), .almost_empty(almost_empty), .count(count),
    .wovf(wovf), .rudf(rudf), .ram_wenc(ram_wenc), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_renc(ram_renc), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM macro with registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wenc) mem[ram_waddr] <= ram_wdata;
    if (ram_renc) ram_rdata <= mem[ram_raddr];
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state.
  logic [WIDTH-1:0] q[$];
  int               wr_total = 0;
  int               rd_total = 0;
  logic             exp_rvalid, exp_wovf, exp_rudf, exp_wenc, exp_renc;
  logic [WIDTH-1:0] exp_rdata;
  logic [3:0]       exp_waddr, exp_raddr;
  logic             s_wenc, s_renc;
  logic [3:0]       s_waddr, s_raddr;

  // One clock of stimulus: drive after the falling edge, snapshot the
  // combinational RAM controls, advance the model, settle after the rising edge.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
    bit full_m, empty_m;
    @(negedge clk);
    winc = w; rinc = r; wdata = d;
    #1;
    s_wenc = ram_wenc; s_waddr = ram_waddr; s_renc = ram_renc; s_raddr = ram_raddr;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    exp_wenc  = w && !full_m;
    exp_renc  = r && !empty_m;
    exp_waddr = 4'(wr_total % DEPTH);
    exp_raddr = 4'(rd_total % DEPTH);
    exp_wovf  = w && full_m;
    exp_rudf  = r && empty_m;
    exp_rvalid = exp_renc;
    if (exp_renc) begin exp_rdata = q.pop_front(); rd_total++; end
    if (exp_wenc) begin q.push_back(d); wr_total++; end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    wr_total = 0;
    rd_total = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (rempty !== 1'b1) $display("FAIL reset_rempty got %b want 1", rempty); else pass_cnt++;
    total_cnt++; if (wfull !== 1'b0) $display("FAIL reset_wfull got %b want 0", wfull); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (almost_empty !== 1'b1) $display("FAIL reset_almost_empty got %b want 1", almost_empty); else pass_cnt++;
    total_cnt++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full got %b want 0", almost_full); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got %b want 0", rvalid); else pass_cnt++;
    total_cnt++; if (ram_wenc !== 1'b0 || ram_renc !== 1'b0) $display("FAIL reset_ram_en got %b%b want 00", ram_wenc, ram_renc); else pass_cnt++;
    total_cnt++; if (wovf !== 1'b0 || rudf !== 1'b0) $display("FAIL reset_pulses got %b%b want 00", wovf, rudf); else pass_cnt++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(i));
      total_cnt++; if (count !== 5'(i)) $display("FAIL fill_count got %0d want %0d", count, i); else pass_cnt++;
      total_cnt++; if (almost_full !== (i >= DEPTH - 2)) $display("FAIL fill_almost_full at %0d got %b", i, almost_full); else pass_cnt++;
      total_cnt++; if (wfull !== (i == DEPTH)) $display("FAIL fill_wfull at %0d got %b", i, wfull); else pass_cnt++;
      total_cnt++; if (almost_empty !== (i <= 2)) $display("FAIL fill_almost_empty at %0d got %b", i, almost_empty); else pass_cnt++;
      total_cnt++; if (s_wenc !== 1'b1 || s_waddr !== exp_waddr) $display("FAIL fill_ram_write got %b/%0d want 1/%0d", s_wenc, s_waddr, exp_waddr); else pass_cnt++;
    end
    step(1'b1, 1'b0, 8'h11);
    total_cnt++; if (wovf !== 1'b1) $display("FAIL overflow_wovf got %b want 1", wovf); else pass_cnt++;
    total_cnt++; if (count !== 5'd16) $display("FAIL overflow_count got %0d want 16", count); else pass_cnt++;
    total_cnt++; if (s_wenc !== 1'b0) $display("FAIL overflow_ram_wenc got %b want 0", s_wenc); else pass_cnt++;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (wovf !== 1'b0) $display("FAIL overflow_pulse_width got %b want 0", wovf); else pass_cnt++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00);
      total_cnt++; if (rvalid !== 1'b1) $display("FAIL drain_rvalid at %0d got %b want 1", i, rvalid); else pass_cnt++;
      total_cnt++; if (rdata !== 8'(i)) $display("FAIL drain_rdata got %0h want %0h", rdata, 8'(i)); else pass_cnt++;
      total_cnt++; if (rempty !== (i == DEPTH)) $display("FAIL drain_rempty at %0d got %b", i, rempty); else pass_cnt++;
      total_cnt++; if (s_raddr !== exp_raddr) $display("FAIL drain_raddr got %0d want %0d", s_raddr, exp_raddr); else pass_cnt++;
    end
    step(1'b0, 1'b1, 8'h00);
    total_cnt++; if (rudf !== 1'b1) $display("FAIL underflow_rudf got %b want 1", rudf); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL underflow_rvalid got %b want 0", rvalid); else pass_cnt++;
    total_cnt++; if (s_renc !== 1'b0) $display("FAIL underflow_ram_renc got %b want 0", s_renc); else pass_cnt++;
    step(1'b0, 1'b0, 8'h00);
    total_cnt++; if (rudf !== 1'b0) $display("FAIL underflow_pulse_width got %b want 0", rudf); else pass_cnt++;
  endtask

  task automatic test_stream_wrap();
    logic [WIDTH-1:0] d = 8'h40;
    for (int i = 0; i < 8; i++) begin step(1'b1, 1'b0, d); d++; end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, d); d++;
      total_cnt++; if (count !== 5'd8) $display("FAIL stream_count got %0d want 8", count); else pass_cnt++;
      total_cnt++; if (rvalid !== 1'b1 || rdata !== exp_rdata) $display("FAIL stream_data got %b/%0h want 1/%0h", rvalid, rdata, exp_rdata); else pass_cnt++;
      total_cnt++; if (s_waddr !== exp_waddr || s_raddr !== exp_raddr) $display("FAIL stream_addr got %0d/%0d want %0d/%0d", s_waddr, s_raddr, exp_waddr, exp_raddr); else pass_cnt++;
    end
  endtask

  task automatic test_full_empty_both();
    while (q.size() < DEPTH) step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 8'hEE);
    total_cnt++; if (wovf !== 1'b1) $display("FAIL full_both_wovf got %b want 1", wovf); else pass_cnt++;
    total_cnt++; if (count !== 5'd15) $display("FAIL full_both_count got %0d want 15", count); else pass_cnt++;
    total_cnt++; if (wfull !== 1'b0) $display("FAIL full_both_wfull got %b want 0", wfull); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b1 || rdata !== exp_rdata) $display("FAIL full_both_data got %b/%0h want 1/%0h", rvalid, rdata, exp_rdata); else pass_cnt++;
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h5A);
    total_cnt++; if (rudf !== 1'b1) $display("FAIL empty_both_rudf got %b want 1", rudf); else pass_cnt++;
    total_cnt++; if (count !== 5'd1) $display("FAIL empty_both_count got %0d want 1", count); else pass_cnt++;
    total_cnt++; if (rempty !== 1'b0) $display("FAIL empty_both_rempty got %b want 0", rempty); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL empty_both_rvalid got %b want 0", rvalid); else pass_cnt++;
    step(1'b0, 1'b1, 8'h00);
    total_cnt++; if (rdata !== 8'h5A || rvalid !== 1'b1) $display("FAIL empty_both_readback got %b/%0h want 1/5a", rvalid, rdata); else pass_cnt++;
  endtask

  task automatic test_random();
    int pw, pr;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        pw = ((i / 50) % 2 == 0) ? 80 : 25;
        pr = 105 - pw;
      end
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
      total_cnt++; if (count !== 5'(q.size())) $display("FAIL rand_count got %0d want %0d", count, q.size()); else pass_cnt++;
      total_cnt++; if (wfull !== (q.size() == DEPTH) || rempty !== (q.size() == 0)) $display("FAIL rand_full_empty got %b%b size %0d", wfull, rempty, q.size()); else pass_cnt++;
      total_cnt++; if (almost_full !== (q.size() >= DEPTH - 2) || almost_empty !== (q.size() <= 2)) $display("FAIL rand_almost got %b%b size %0d", almost_full, almost_empty, q.size()); else pass_cnt++;
      total_cnt++; if (rvalid !== exp_rvalid || (exp_rvalid && rdata !== exp_rdata)) $display("FAIL rand_read got %b/%0h want %b/%0h", rvalid, rdata, exp_rvalid, exp_rdata); else pass_cnt++;
      total_cnt++; if (wovf !== exp_wovf || rudf !== exp_rudf) $display("FAIL rand_pulses got %b%b want %b%b", wovf, rudf, exp_wovf, exp_rudf); else pass_cnt++;
      total_cnt++; if (s_wenc !== exp_wenc || s_renc !== exp_renc) $display("FAIL rand_ram_en got %b%b want %b%b", s_wenc, s_renc, exp_wenc, exp_renc); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
    step(1'b0, 1'b1, 8'h00);
    total_cnt++; if (count !== 5'd5 || rvalid !== 1'b1) $display("FAIL arst_pre got %0d/%b want 5/1", count, rvalid); else pass_cnt++;
    // rinc stays high: the next pop is in flight when reset hits.
    #1 rst = 1'b1;
    #1;
    total_cnt++; if (count !== 5'd0) $display("FAIL arst_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (rempty !== 1'b1 || almost_empty !== 1'b1) $display("FAIL arst_empty_flags got %b%b want 11", rempty, almost_empty); else pass_cnt++;
    total_cnt++; if (wfull !== 1'b0 || almost_full !== 1'b0) $display("FAIL arst_full_flags got %b%b want 00", wfull, almost_full); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL arst_rvalid got %b want 0", rvalid); else pass_cnt++;
    total_cnt++; if (ram_renc !== 1'b0) $display("FAIL arst_ram_renc got %b want 0", ram_renc); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL arst_rvalid_held got %b want 0", rvalid); else pass_cnt++;
    @(negedge clk);
    rinc = 1'b0; winc = 1'b0; rst = 1'b0;
    model_clear();
    step(1'b1, 1'b0, 8'hA5);
    total_cnt++; if (count !== 5'd1 || s_waddr !== 4'd0) $display("FAIL arst_restart got %0d/%0d want 1/0", count, s_waddr); else pass_cnt++;
    step(1'b0, 1'b1, 8'h00);
    total_cnt++; if (rvalid !== 1'b1 || rdata !== 8'hA5) $display("FAIL arst_readback got %b/%0h want 1/a5", rvalid, rdata); else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream_wrap();
    test_full_empty_both();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that drives the write and read ports of the team's dual-port RAM macro (DEPTH x WIDTH, registered read). It owns the pointer, flag and count logic and presents a push/pop interface to the surrounding datapath. The RAM sits directly downstream: both RAM clocks are tied to clk, and the RAM's registered read data returns through this block to the consumer.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
WIDTH, 8, data width in bits
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  in  1  single clock for all logic and both RAM ports
rst  in  1  asynchronous, active-high reset
winc  in  1  push request
wdata  in  WIDTH  push data
wfull  out  1  FIFO full (registered)
almost_full  out  1  count >= AF_LEVEL (registered)
rinc  in  1  pop request
rdata  out  WIDTH  pop data, valid when rvalid=1
rvalid  out  1  rdata valid, one cycle after accepted pop
rempty  out  1  FIFO empty (registered)
almost_empty  out  1  count <= AE_LEVEL (registered)
count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
wovf  out  1  one-cycle pulse: push rejected because full
rudf  out  1  one-cycle pulse: pop rejected because empty
ram_wenc  out  1  RAM write enable
ram_waddr  out  $clog2(DEPTH)  RAM write address
ram_wdata  out  WIDTH  RAM write data
ram_renc  out  1  RAM read enable
ram_raddr  out  $clog2(DEPTH)  RAM read address
ram_rdata  in  WIDTH  RAM registered read data

Behaviour:
- Clock: clk; reset: rst, asynchronous, active-high. All state flops reset asynchronously.
- Reset values: wptr=0, rptr=0, count=0, wfull=0, almost_full=0, rempty=1, almost_empty=1, rvalid=0, wovf=0, rudf=0. rdata is undefined until the first rvalid.
- Pointers wptr/rptr are $clog2(DEPTH)+1 bits. RAM addresses use the low bits; the MSB is the wrap bit.
- Accept rules use the registered flags: push_ok = winc & ~wfull; pop_ok = rinc & ~rempty.
- ram_wenc = push_ok, ram_waddr = wptr[low], ram_wdata = wdata, all combinational. wptr increments on push_ok.
- ram_renc = pop_ok, ram_raddr = rptr[low], combinational. rptr increments on pop_ok.
- Read latency: 1 cycle. rvalid is registered pop_ok. rdata = ram_rdata passed through.
- count next = count + push_ok - pop_ok. Push and pop in the same cycle leave count unchanged.
- Flags are registered from next-state values, so they are correct in the cycle after the update:
  - wfull = (next wptr, next rptr) low bits equal and MSBs differ.
  - rempty = next pointers fully equal.
  - almost_full and almost_empty are compared against next count.
- Wrap-around: pointers roll over naturally. After 2*DEPTH pushes the wptr MSB returns to 0.
- Full + winc + rinc: the pop is accepted, the push is rejected, and wovf pulses. In the next cycle wfull=0 and count=DEPTH-1.
- Empty + winc + rinc: the push is accepted, the pop is rejected, and rudf pulses. In the next cycle rempty=0 and count=1. No bypass path exists.
- wovf = winc & wfull, rudf = rinc & rempty, both registered as one-cycle pulses. Pointers are unchanged on rejection.
- Reset mid-operation: all state returns to reset values immediately. Contents are discarded logically; RAM contents are not cleared. A pending rvalid is dropped.

Test Plan:
- Reset, then idle 3 cycles -> rempty=1, wfull=0, count=0, almost_empty=1, rvalid=0, ram_wenc=ram_renc=0.
- Push 0x01..0x10 (16 words) on consecutive cycles -> wfull=1 the cycle after the 16th push, count=16, almost_full=1 from count 14. A 17th push -> wovf pulses once and count stays 16.
- Pop 16 words back-to-back -> rvalid each cycle after the corresponding rinc, rdata sequence 0x01..0x10, rempty=1 after the last pop. An extra pop -> rudf pulses once.
- Fill 8 words, then push and pop simultaneously for 40 cycles with incrementing data -> count holds 8, data is in order, and pointers wrap twice with no corruption.
- At full, assert winc and rinc together -> pop accepted, push rejected, wovf=1, next-cycle count=15. At empty, assert both -> push accepted, rudf=1, next-cycle count=1.
- Assert rst asynchronously mid-stream with count=5 and a pop in flight -> all flags and count return to reset values before the next clk edge, and rvalid is not asserted for the in-flight pop.
